// File: rtl/dkong_pkg.sv
// rtl/dkong_pkg.sv - shared state encoding and default constants for the bus-hold arbiter
package dkong_pkg;

  // Bus ownership phases of the sprite-DMA hold handshake
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_GRANT   = 3'd3,
    ST_RELEASE = 3'd4
  } hold_state_t;

  localparam logic [2:0]  DKONG_SETTLE_CYC_DEF  = 3'd1;
  localparam logic [11:0] DKONG_TIMEOUT_CYC_DEF = 12'hFFF;

  // The DMA side owns the sprite-RAM buses only while the grant is held
  function automatic logic is_dma_owner(input hold_state_t s);
    return (s == ST_GRANT);
  endfunction

endpackage

// File: rtl/dkong_bus_hold_mux.sv
// rtl/dkong_bus_hold_mux.sv - combinational CPU/DMA select for the work-RAM and sprite-RAM buses
module dkong_bus_hold_mux
  import dkong_pkg::*;
(
  input  logic [2:0] i_state,
  input  logic [9:0] i_cpu_a,
  input  logic [7:0] i_cpu_do,
  input  logic       i_cpu_we,
  input  logic [9:0] i_dma_as,
  input  logic [9:0] i_dma_ad,
  input  logic [7:0] i_dma_dd,
  input  logic       i_dma_ces,
  input  logic       i_dma_ced,
  output logic [9:0] o_src_a,
  output logic       o_src_ce,
  output logic [9:0] o_dst_a,
  output logic [7:0] o_dst_d,
  output logic       o_dst_we
);

  logic w_dma_sel;

  assign w_dma_sel = is_dma_owner(hold_state_t'(i_state));

  // Route DMA buses during grant, otherwise CPU buses with DMA chip enables masked off
  always_comb begin
    o_src_a  = i_cpu_a;
    o_src_ce = 1'b0;
    o_dst_a  = i_cpu_a;
    o_dst_d  = i_cpu_do;
    o_dst_we = i_cpu_we;
    if (w_dma_sel) begin
      o_src_a  = i_dma_as;
      o_src_ce = i_dma_ces;
      o_dst_a  = i_dma_ad;
      o_dst_d  = i_dma_dd;
      o_dst_we = i_dma_ced;
    end
  end

endmodule

// File: rtl/dkong_bus_hold.sv
// rtl/dkong_bus_hold.sv - Z80 bus-hold arbiter for sprite DMA; optional ack timeout via DKONG_HOLD_TIMEOUT_EN
module dkong_bus_hold
  import dkong_pkg::*;
#(
  parameter logic [2:0]  SETTLE_CYC  = DKONG_SETTLE_CYC_DEF,
  parameter logic [11:0] TIMEOUT_CYC = DKONG_TIMEOUT_CYC_DEF
) (
  input  logic       I_CLK,
  input  logic       I_RSTn,
  input  logic       I_CLK_EN,
  input  logic       I_HRQ,
  output logic       O_HLDA,
  output logic       O_CPU_BUSRQn,
  input  logic       I_CPU_BUSAKn,
  input  logic [9:0] I_CPU_A,
  input  logic [7:0] I_CPU_DO,
  input  logic       I_CPU_WE,
  input  logic [9:0] I_DMA_AS,
  input  logic [9:0] I_DMA_AD,
  input  logic [7:0] I_DMA_DD,
  input  logic       I_DMA_CES,
  input  logic       I_DMA_CED,
  output logic [9:0] O_SRC_A,
  output logic       O_SRC_CE,
  output logic [9:0] O_DST_A,
  output logic [7:0] O_DST_D,
  output logic       O_DST_WE,
  output logic       O_HOLD_ERR
);

  hold_state_t r_state;
  logic        r_hlda;
  logic        r_busrq_n;
  logic [2:0]  r_settle_cnt;
  logic        w_to_fire;

`ifdef DKONG_HOLD_TIMEOUT_EN
  logic [11:0] r_to_cnt;
  logic        r_hold_err;

  // Timeout fires on the enabled edge that completes TIMEOUT_CYC cycles waiting in REQ with no ack
  assign w_to_fire = (r_state == ST_REQ) && I_HRQ && I_CPU_BUSAKn &&
                     (r_to_cnt == 12'(TIMEOUT_CYC - 12'd1));

  // Count enabled cycles spent in REQ; cleared whenever REQ is not the current state
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      r_to_cnt <= 12'd0;
    end else if (I_CLK_EN) begin
      if (r_state == ST_REQ) begin
        r_to_cnt <= r_to_cnt + 12'd1;
      end else begin
        r_to_cnt <= 12'd0;
      end
    end
  end

  // Sticky error flag; only reset clears it
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      r_hold_err <= 1'b0;
    end else if (I_CLK_EN && w_to_fire) begin
      r_hold_err <= 1'b1;
    end
  end

  assign O_HOLD_ERR = r_hold_err;
`else
  logic w_unused_timeout;

  assign w_to_fire        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign O_HOLD_ERR       = 1'b0;
`endif

  // Hold handshake FSM with registered HLDA and BUSRQn
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      r_state      <= ST_IDLE;
      r_hlda       <= 1'b0;
      r_busrq_n    <= 1'b1;
      r_settle_cnt <= 3'd0;
    end else if (I_CLK_EN) begin
      case (r_state)
        ST_IDLE: begin
          if (I_HRQ) begin
            r_state   <= ST_REQ;
            r_busrq_n <= 1'b0;
          end
        end
        ST_REQ: begin
          if (!I_HRQ || w_to_fire) begin
            r_state   <= ST_RELEASE;
            r_busrq_n <= 1'b1;
          end else if (!I_CPU_BUSAKn) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= 3'(SETTLE_CYC - 3'd1);
          end
        end
        ST_SETTLE: begin
          if (!I_HRQ) begin
            r_state   <= ST_RELEASE;
            r_busrq_n <= 1'b1;
          end else if (r_settle_cnt == 3'd0) begin
            r_state <= ST_GRANT;
            r_hlda  <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt - 3'd1;
          end
        end
        ST_GRANT: begin
          // Normal end of DMA, or the CPU withdrew its ack while we still held the bus
          if (!I_HRQ || I_CPU_BUSAKn) begin
            r_state   <= ST_RELEASE;
            r_hlda    <= 1'b0;
            r_busrq_n <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (I_CPU_BUSAKn) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_hlda    <= 1'b0;
          r_busrq_n <= 1'b1;
        end
      endcase
    end
  end

  assign O_HLDA       = r_hlda;
  assign O_CPU_BUSRQn = r_busrq_n;

  dkong_bus_hold_mux u_mux (
    .i_state   (r_state),
    .i_cpu_a   (I_CPU_A),
    .i_cpu_do  (I_CPU_DO),
    .i_cpu_we  (I_CPU_WE),
    .i_dma_as  (I_DMA_AS),
    .i_dma_ad  (I_DMA_AD),
    .i_dma_dd  (I_DMA_DD),
    .i_dma_ces (I_DMA_CES),
    .i_dma_ced (I_DMA_CED),
    .o_src_a   (O_SRC_A),
    .o_src_ce  (O_SRC_CE),
    .o_dst_a   (O_DST_A),
    .o_dst_d   (O_DST_D),
    .o_dst_we  (O_DST_WE)
  );

endmodule

// File: doc/dkong_bus_hold.md
DKONG_BUS_HOLD -- requirements
Module: dkong_bus_hold

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1, meaning the number of enabled cycles between CPU bus-acknowledge and HLDA assertion (range 1-7).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 12'hFFF, meaning the number of enabled cycles allowed for the CPU to acknowledge (used only with DKONG_HOLD_TIMEOUT_EN).
REQ-003 SHALL have port I_CLK, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port I_RSTn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port I_CLK_EN, input, 1, clock enable; state advances only when high.
REQ-006 SHALL have port I_HRQ, input, 1, hold request from the sprite DMA initiator.
REQ-007 SHALL have port O_HLDA, output, 1, hold acknowledge to the DMA initiator.
REQ-008 SHALL have port O_CPU_BUSRQn, output, 1, active-low bus request to the Z80.
REQ-009 SHALL have port I_CPU_BUSAKn, input, 1, active-low bus acknowledge from the Z80.
REQ-010 SHALL have ports I_CPU_A (input, 10), I_CPU_DO (input, 8) and I_CPU_WE (input, 1): CPU sprite-RAM address, write data and write strobe.
REQ-011 SHALL have ports I_DMA_AS (input, 10), I_DMA_AD (input, 10), I_DMA_DD (input, 8), I_DMA_CES (input, 1) and I_DMA_CED (input, 1): DMA source address, destination address, data and chip enables.
REQ-012 SHALL have ports O_SRC_A (output, 10) and O_SRC_CE (output, 1): the source work-RAM address and chip enable after muxing.
REQ-013 SHALL have ports O_DST_A (output, 10), O_DST_D (output, 8) and O_DST_WE (output, 1): the destination sprite-RAM address, data and write enable.
REQ-014 SHALL have port O_HOLD_ERR, output, 1, sticky acknowledge-timeout flag.

Function
REQ-015 SHALL implement the states IDLE, REQ, SETTLE, GRANT and RELEASE.
REQ-016 In IDLE, I_HRQ=1 SHALL move the block to REQ and assert O_CPU_BUSRQn=0 on the same edge.
REQ-017 In REQ, I_CPU_BUSAKn=0 SHALL move the block to SETTLE and load the settle counter with SETTLE_CYC-1.
REQ-018 SETTLE SHALL count down and move to GRANT when the counter reaches 0; O_HLDA SHALL be registered high from GRANT entry.
REQ-019 In GRANT, I_HRQ=0 SHALL move the block to RELEASE, deassert O_HLDA, and set O_CPU_BUSRQn=1 on the same edge.
REQ-020 RELEASE SHALL wait for I_CPU_BUSAKn=1, then return to IDLE; an I_HRQ held at 1 SHALL be ignored until IDLE is reached.
REQ-021 A drop of I_HRQ in REQ or SETTLE SHALL abort: the block releases BUSRQ and goes to RELEASE without ever asserting HLDA.
REQ-022 I_CPU_BUSAKn rising during GRANT is a protocol error: the block SHALL drop O_HLDA and go to RELEASE.
REQ-023 In GRANT only, the muxes SHALL select the DMA side: O_SRC_A=I_DMA_AS, O_SRC_CE=I_DMA_CES, O_DST_A=I_DMA_AD, O_DST_D=I_DMA_DD, O_DST_WE=I_DMA_CED.
REQ-024 In all other states, the muxes SHALL select the CPU side: O_DST_A=I_CPU_A, O_DST_D=I_CPU_DO, O_DST_WE=I_CPU_WE, O_SRC_CE=0, and DMA chip enables are ignored.
REQ-025 Mux outputs SHALL be combinational from the registered state; there is zero added latency on data paths.
REQ-026 While I_CLK_EN=0, all registers SHALL hold their values.

Reset
REQ-027 Asserting I_RSTn=0 SHALL asynchronously force IDLE, O_HLDA=0, O_CPU_BUSRQn=1, O_HOLD_ERR=0, and clear all counters, including when reset hits mid-GRANT.
REQ-028 Release of reset SHALL be sampled synchronously; the first transition is possible on the first enabled edge.

Configuration
REQ-029 With DKONG_HOLD_TIMEOUT_EN defined, a 12-bit counter SHALL run in REQ; reaching TIMEOUT_CYC SHALL set O_HOLD_ERR (cleared only by reset) and go to RELEASE.
REQ-030 Without DKONG_HOLD_TIMEOUT_EN, REQ SHALL wait indefinitely, O_HOLD_ERR SHALL be constant 0, and no timeout counter SHALL exist.

Structure
REQ-031 The state encoding (3-bit enum) and the default constants for SETTLE_CYC and TIMEOUT_CYC SHALL live in the shared package dkong_pkg.
REQ-032 The bus mux SHALL be the sub-module dkong_bus_hold_mux (purely combinational, with the state select as input); the FSM stays in the top module.

Verification
REQ-033 HRQ=1 with BUSAKn dropping 3 cycles later, SETTLE_CYC=1 -> BUSRQn=0 the next cycle, HLDA=1 exactly 1 enabled cycle after BUSAKn=0.
REQ-034 In GRANT, DMA_AD=10'h005, DMA_DD=8'hA5, CED=1 -> O_DST_A=10'h005, O_DST_D=8'hA5, O_DST_WE=1; CPU_WE=1 is ignored.
REQ-035 HRQ dropped in SETTLE -> HLDA never rises, BUSRQn=1 next cycle, IDLE after BUSAKn=1.
REQ-036 I_RSTn=0 mid-GRANT -> HLDA=0 and BUSRQn=1 immediately, without waiting for a clock edge.
REQ-037 With DKONG_HOLD_TIMEOUT_EN and TIMEOUT_CYC=16, BUSAKn held at 1 -> O_HOLD_ERR=1 after 16 enabled cycles and state is RELEASE; without the macro, the block remains in REQ after 5000 cycles.
REQ-038 I_CLK_EN toggling 1-in-4 -> all state timings scale by 4; no transition occurs on a disabled edge.
